// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: shared format encodings, request record and the RV32I immediate scatter
package imm_enc_pkg;
  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_ISH = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5
  } fmt_e;
  localparam logic [31:0] ILLEGAL_INSTR = 32'hffffffff;
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        err;
  } req_t;
  function automatic logic [31:0] encode(input req_t r);
    return r.err ? ILLEGAL_INSTR :
      r.fmt == FMT_I   ? {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode} :
      r.fmt == FMT_ISH ? {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, r.opcode} :
      r.fmt == FMT_S   ? {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode} :
      r.fmt == FMT_B   ? {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3, r.imm[4:1], r.imm[11], r.opcode} :
      r.fmt == FMT_U   ? {r.imm[31:12], r.rd, r.opcode} :
      r.fmt == FMT_J   ? {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode} :
      ILLEGAL_INSTR;
  endfunction
endpackage

// File: rtl/imm_enc_range_chk.sv
// imm_range_chk: flags immediates that the selected format cannot represent
module imm_range_chk
  import imm_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);
  logic s11, s12, s20;
  assign s11 = &imm[31:11] | ~|imm[31:11];
  assign s12 = &imm[31:12] | ~|imm[31:12];
  assign s20 = &imm[31:20] | ~|imm[31:20];
  // sign-extension checks per format; B/J offsets must also be halfword aligned
  always_comb begin
    err = (fmt == FMT_I || fmt == FMT_S) ? ~s11 :
          fmt == FMT_ISH ? |imm[31:5] :
          fmt == FMT_B   ? ~s12 | imm[0] :
          fmt == FMT_J   ? ~s20 | imm[0] :
          fmt == FMT_U   ? |imm[11:0] :
          1'b1;
  end
endmodule

// File: rtl/imm_enc.sv
// imm_enc: two-stage valid/ready encoder packing immediate and register fields into RV32I words
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_fmt,
  input  logic [6:0]           i_opcode,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  input  logic [XLEN-1:0]      i_imm,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  logic v1, adv1, adv2, range_err;
  req_t r1;
  imm_range_chk u_chk (.fmt(i_fmt), .imm(i_imm), .err(range_err));
  assign adv2    = ~o_valid | i_ready;
  assign adv1    = ~v1 | adv2;
  assign o_ready = adv1;
  // stage 1: capture fields together with the range verdict
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else if (adv1) begin
      v1 <= i_valid;
      if (i_valid)
        r1 <= '{fmt: i_fmt, opcode: i_opcode, rd: i_rd, rs1: i_rs1, rs2: i_rs2,
                funct3: i_funct3, funct7: i_funct7, imm: i_imm, err: range_err};
    end
  end
  // stage 2: scatter immediate bits and hold the result until accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_instr <= '0;
      o_err   <= 1'b0;
    end else if (adv2) begin
      o_valid <= v1;
      if (v1) begin
        o_instr <= encode(r1);
        o_err   <= r1.err;
      end
    end
  end
  // saturating count of errored results taken downstream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_err_cnt <= '0;
    else if (o_valid && i_ready && o_err && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
  end
endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
- Inverse of the core's immediate decoder: packs an XLEN immediate and register/funct fields into a 32-bit RV32I instruction word.
- Feeds the debug program-buffer and self-test instruction injectors.
- Two-stage valid/ready pipeline. Stage 1 registers fields and range-checks the immediate. Stage 2 scatters the immediate bits per format and presents the instruction.
- Immediates that cannot be encoded are flagged, not silently truncated.

Parameters:
XLEN, 32, immediate input width; only 32 is supported.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream request valid
o_ready  output  1  stage 1 can accept a request
i_fmt  input  3  0=I, 1=I-shift, 2=S, 3=B, 4=U, 5=J, 6-7 illegal
i_opcode  input  7  placed at [6:0]
i_rd  input  5  placed at [11:7] for I, I-shift, U, J
i_rs1  input  5  placed at [19:15] for I, I-shift, S, B
i_rs2  input  5  placed at [24:20] for S, B
i_funct3  input  3  placed at [14:12] for I, I-shift, S, B
i_funct7  input  7  placed at [31:25] for I-shift only
i_imm  input  XLEN  immediate, byte offset for B/J
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_instr  output  32  encoded instruction
o_err  output  1  immediate not representable, or illegal format
o_err_cnt  output  ERR_CNT_W  saturating count of errored results accepted downstream

Behaviour:
- Reset (async assert, sync release): o_valid=0, both stage-valid flags=0, o_instr=0, o_err=0, o_err_cnt=0. o_ready=1 after reset.
- Handshakes:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - Once o_valid=1, o_instr, o_err and o_valid hold stable until i_ready=1.
- Ready chain:
  - Stage 2 advances when it is empty or i_ready=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - o_ready = stage-1 advance condition. This is combinational from i_ready by design.
- Latency: 2 cycles from accept to o_valid with no backpressure. Throughput: 1 per cycle. Capacity: 2 in flight.
- Range check in stage 1, err=1 when:
  - I, S: i_imm[31:11] not all equal (must be 12-bit signed).
  - I-shift: i_imm[31:5] != 0.
  - B: i_imm[31:12] not all equal, or i_imm[0]=1.
  - J: i_imm[31:20] not all equal, or i_imm[0]=1.
  - U: i_imm[11:0] != 0.
  - fmt 6 or 7: always.
- Bit scatter in stage 2, standard RV32I:
  - I: imm[11:0]->[31:20].
  - I-shift: funct7->[31:25], imm[4:0]->[24:20].
  - S: imm[11:5]->[31:25], imm[4:0]->[11:7].
  - B: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
  - U: imm[31:12]->[31:12].
  - J: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
- On err=1: o_instr=32'hffffffff, o_err=1.
- o_err_cnt:
  - Increments on each downstream transfer with o_err=1.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Simultaneous accept and drain in both stages: full throughput, no bubble, order preserved.
- Reset mid-operation: in-flight entries are discarded, no partial output.

Decomposition:
- Shared package/header: format encodings (FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J) and the ILLEGAL_INSTR constant 32'hffffffff.
- These sit alongside the existing opcode macros so decoder and encoder share definitions.
- One natural sub-module, imm_range_chk: combinational fmt+imm -> err, reused by the assembler test harness.

Test Plan:
1. fmt=I, opcode=0x13, rd=1, rs1=2, funct3=0, imm=-1 -> o_instr=0xfff10093, o_err=0, o_valid 2 cycles after accept.
2. fmt=B, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xfe208ee3. Same fields with imm=3 -> 0xffffffff, o_err=1, o_err_cnt=1.
3. fmt=J, opcode=0x6f, rd=1, imm=0x800 -> 0x001000ef. imm=0x100000 -> o_err=1.
4. fmt=U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452b7. imm=0x12345001 -> o_err=1. fmt=I-shift, opcode=0x13, rd=3, rs1=3, funct3=1, funct7=0, imm=31 -> 0x01f19193. imm=32 -> o_err=1.
5. Stream 4 back-to-back requests, hold i_ready=0 for 3 cycles:
   - o_ready drops after 2 accepts; o_instr stays stable.
   - All 4 emerge in order with no loss or duplicate.
   - With i_ready=1 continuously: 1 result per cycle.
6. Assert i_rst_n low with 2 entries in flight -> o_valid=0 and o_err_cnt=0 immediately. After release, the first new request completes in 2 cycles. Force 300 errors with ERR_CNT_W=8 -> o_err_cnt=255.
